// File: rtl/trace_pkg.sv
// Shared types and constants for the CPU execution-trace capture block.
package trace_pkg;

  localparam int DEFAULT_DW = 32;
  localparam int ENTRY_W    = 2 * DEFAULT_DW + 1;
  localparam logic [15:0] OVF_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_HALT_PEND = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Entry layout is {pc, alures, last}.
  function automatic int entry_width(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Register-array FIFO with first-word-fall-through head and occupancy counter.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push_s = push & (~full | do_pop_s);

  // Head is forced to zero when empty so no stale entry is ever visible.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures one trace entry per pc change of the CPU core, terminated by a halt
// marker, and hands entries to a host over a valid/ready FIFO port.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = DEFAULT_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DW-1:0]            cpu_pc,
  input  logic [DW-1:0]            cpu_alures,
  input  logic                     cpu_halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_pc,
  output logic [DW-1:0]            out_alures,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              overflow_cnt,
  output logic                     done
);

  localparam int EW = entry_width(DW);

  state_e          state_q, state_d;
  logic            first_q, first_d;
  logic [DW-1:0]   last_pc_q, last_pc_d;
  logic            halt_prev_q, halt_prev_d;
  logic [DW-1:0]   mark_pc_q, mark_pc_d;
  logic [DW-1:0]   mark_alu_q, mark_alu_d;
  logic [15:0]     ovf_q, ovf_d;
  logic            done_q, done_d;

  logic            push_s, drop_s, pop_s, space_s;
  logic            halt_rise_s, sample_s;
  logic [EW-1:0]   push_data_s, head_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [$clog2(DEPTH):0] count_s;

  assign pop_s       = ~fifo_empty_s & out_ready;
  assign space_s     = ~fifo_full_s | pop_s;
  assign halt_rise_s = cpu_halt & ~halt_prev_q;
  assign sample_s    = first_q | (cpu_pc != last_pc_q);

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_pc_d   = last_pc_q;
    halt_prev_d = cpu_halt;
    mark_pc_d   = mark_pc_q;
    mark_alu_d  = mark_alu_q;
    push_s      = 1'b0;
    drop_s      = 1'b0;
    push_data_s = {cpu_pc, cpu_alures, 1'b0};
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CAPTURE;
          first_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (halt_rise_s) begin
          push_data_s = {cpu_pc, cpu_alures, 1'b1};
          if (space_s) begin
            push_s  = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            // Marker must never be lost: park it until a slot opens.
            mark_pc_d  = cpu_pc;
            mark_alu_d = cpu_alures;
            state_d    = ST_HALT_PEND;
          end
        end else if (sample_s) begin
          last_pc_d = cpu_pc;
          first_d   = 1'b0;
          if (space_s) begin
            push_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_HALT_PEND: begin
        push_data_s = {mark_pc_q, mark_alu_q, 1'b1};
        if (space_s) begin
          push_s  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_HALT_PEND;
        end
      end
      ST_DRAIN: begin
        if (count_s == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop_s && (ovf_q != OVF_SAT)) begin
      ovf_d = ovf_q + 16'd1;
    end else begin
      ovf_d = ovf_q;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      first_q     <= 1'b0;
      last_pc_q   <= '0;
      halt_prev_q <= 1'b0;
      mark_pc_q   <= '0;
      mark_alu_q  <= '0;
      ovf_q       <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      last_pc_q   <= last_pc_d;
      halt_prev_q <= halt_prev_d;
      mark_pc_q   <= mark_pc_d;
      mark_alu_q  <= mark_alu_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (count_s)
  );

  assign out_valid    = ~fifo_empty_s;
  assign out_pc       = head_s[2*DW:DW+1];
  assign out_alures   = head_s[DW:1];
  assign out_last     = head_s[0];
  assign count        = count_s;
  assign overflow_cnt = ovf_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer (DEPTH=16, DW=32).
module tb_cpu_trace_buffer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_alures;
  logic        cpu_halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_alures;
  logic        out_last;
  logic [4:0]  count;
  logic [15:0] overflow_cnt;
  logic        done;

  int checks;
  int failures;

  cpu_trace_buffer #(.DEPTH(16), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cpu_pc       (cpu_pc),
    .cpu_alures   (cpu_alures),
    .cpu_halt     (cpu_halt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_alures   (out_alures),
    .out_last     (out_last),
    .count        (count),
    .overflow_cnt (overflow_cnt),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow_cnt !== 16'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (out_pc !== 32'd0 || out_alures !== 32'd0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%h/%0h exp=0/0/0", out_pc, out_alures, out_last); end
    #1 rst = 1'b1;
  endtask

  task automatic test_basic_order();
    enable = 1'b1; cpu_pc = 32'h0; cpu_alures = 32'd1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_to_capture valid got=%0h exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_alures !== 32'd1 || out_last !== 1'b0) begin failures++; $display("FAIL basic_e0 got=%0h %h %h %0h exp=1 0 1 0", out_valid, out_pc, out_alures, out_last); end
    cpu_pc = 32'h4; cpu_alures = 32'd2;
    step();
    checks++; if (out_pc !== 32'h4 || out_alures !== 32'd2 || out_last !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL basic_e1 got=%h %h %0h cnt=%0d exp=4 2 0 1", out_pc, out_alures, out_last, count); end
    cpu_pc = 32'h8; cpu_alures = 32'd3;
    step();
    checks++; if (out_pc !== 32'h8 || out_alures !== 32'd3 || out_last !== 1'b0) begin failures++; $display("FAIL basic_e2 got=%h %h %0h exp=8 3 0", out_pc, out_alures, out_last); end
    step();
    checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL basic_drained got=%0h cnt=%0d exp=0 0", out_valid, count); end
  endtask

  task automatic test_hold_pc();
    out_ready = 1'b0; cpu_pc = 32'h10; cpu_alures = 32'h55;
    step();
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL hold_first got=%0d exp=1", count); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (count !== 5'd1 || out_pc !== 32'h10) begin failures++; $display("FAIL hold_steady got=%0d %h exp=1 10", count, out_pc); end
    cpu_pc = 32'h14;
    step();
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL hold_change got=%0d exp=2", count); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h14 || count !== 5'd1) begin failures++; $display("FAIL hold_second got=%h cnt=%0d exp=14 1", out_pc, count); end
    step();
    out_ready = 1'b0;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL hold_drained got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_pc = 32'h100 + 32'(4 * i); cpu_alures = 32'(i);
      step();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    checks++; if (overflow_cnt !== 16'd4) begin failures++; $display("FAIL ovf_cnt got=%0d exp=4", overflow_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_pc !== 32'h100 + 32'(4 * i) || out_alures !== 32'(i)) begin failures++; $display("FAIL ovf_order[%0d] got=%h %h exp=%h %h", i, out_pc, out_alures, 32'h100 + 32'(4 * i), i); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0d %0h exp=0 0", count, out_valid); end
  endtask

  task automatic test_halt_pend();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cpu_pc = 32'h200 + 32'(4 * i); cpu_alures = 32'(i);
      step();
    end
    cpu_pc = 32'h40; cpu_alures = 32'hAA; cpu_halt = 1'b1;
    step();
    checks++; if (count !== 5'd16 || overflow_cnt !== 16'd4) begin failures++; $display("FAIL halt_full got=%0d ovf=%0d exp=16 4", count, overflow_cnt); end
    cpu_pc = 32'h44;
    step();
    checks++; if (count !== 5'd16 || overflow_cnt !== 16'd4 || done !== 1'b0) begin failures++; $display("FAIL halt_pend_ignore got=%0d ovf=%0d done=%0h exp=16 4 0", count, overflow_cnt, done); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 5'd16 || out_pc !== 32'h204) begin failures++; $display("FAIL halt_marker_push got=%0d %h exp=16 204", count, out_pc); end
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++; if (out_pc !== 32'h200 + 32'(4 * i) || out_last !== 1'b0) begin failures++; $display("FAIL halt_drain[%0d] got=%h %0h exp=%h 0", i, out_pc, out_last, 32'h200 + 32'(4 * i)); end
      step();
    end
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b1 || out_pc !== 32'h40 || out_alures !== 32'hAA) begin failures++; $display("FAIL halt_marker got=%0h %0h %h %h exp=1 1 40 aa", out_valid, out_last, out_pc, out_alures); end
    step();
    checks++; if (count !== 5'd0 || done !== 1'b0) begin failures++; $display("FAIL halt_empty got=%0d done=%0h exp=0 0", count, done); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL halt_done got=%0h exp=1", done); end
    out_ready = 1'b0; enable = 1'b0; cpu_halt = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL halt_to_idle got=%0h exp=0", done); end
  endtask

  task automatic test_full_simul();
    enable = 1'b1;
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL simul_start got=%0d exp=0", count); end
    for (int i = 0; i < 16; i++) begin
      cpu_pc = 32'h300 + 32'(4 * i); cpu_alures = 32'(i);
      step();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL simul_fill got=%0d exp=16", count); end
    cpu_pc = 32'h400; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 5'd16 || overflow_cnt !== 16'd4 || out_pc !== 32'h304) begin failures++; $display("FAIL simul_pushpop got=%0d ovf=%0d %h exp=16 4 304", count, overflow_cnt, out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    out_ready = 1'b0;
    checks++; if (count !== 5'd5 || out_pc !== 32'h330) begin failures++; $display("FAIL simul_partial got=%0d %h exp=5 330", count, out_pc); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow_cnt !== 16'd0) begin failures++; $display("FAIL areset_immediate got=%0d %0h ovf=%0d exp=0 0 0", count, out_valid, overflow_cnt); end
    #1 rst = 1'b1;
    cpu_pc = 32'h500; cpu_alures = 32'h7;
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL areset_idle got=%0d exp=0", count); end
    step();
    checks++; if (count !== 5'd1 || out_pc !== 32'h500 || out_alures !== 32'h7) begin failures++; $display("FAIL areset_restart got=%0d %h %h exp=1 500 7", count, out_pc, out_alures); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; enable = 1'b0; cpu_pc = 32'h0; cpu_alures = 32'h0;
    cpu_halt = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_order();
    test_hold_pc();
    test_overflow();
    test_halt_pend();
    test_full_simul();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
